wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter AGE_LIMIT, default 4, meaning the number of consecutive waiting cycles after which a requester becomes starved; legal range 1..7.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 4, per-requester writeback request (k = 0..3).
REQ-005 SHALL have port req_slot_flat, input, 12, instruction slot of requester k at [3k+2:3k]; a higher slot is older.
REQ-006 SHALL have port req_stamp_flat, input, 12, current 3-bit stamp of requester k's slot at [3k+2:3k].
REQ-007 SHALL have port req_rd_flat, input, 20, destination register of requester k at [5k+4:5k].
REQ-008 SHALL have port req_data_flat, input, 128, write data of requester k at [32k+31:32k].
REQ-009 SHALL have port req_ready, output, 4, combinational one-hot grant, asserted in the cycle the request is accepted.
REQ-010 SHALL have port reg_search_in, output, 5, register-file write address, registered.
REQ-011 SHALL have port reg_in, output, 32, register-file write data, registered.
REQ-012 SHALL have port reg_in_start, output, 1, register-file write strobe, registered one-cycle pulse.
REQ-013 SHALL have port stamp_flat, output, 24, stamp for slot s at [3s+2:3s], registered.
REQ-014 SHALL have port stamp_in, output, 8, one-hot stamp strobe per slot, registered one-cycle pulse.

Function
REQ-015 SHALL grant at most one requester per cycle; req_ready SHALL be 0 whenever rst=1 or req_valid=0.
REQ-016 SHALL choose the winner as follows: any starved requester (wait_cnt >= AGE_LIMIT) beats any non-starved one; among candidates in the same class, the highest req_slot wins; on equal slots, the lowest requester index wins.
REQ-017 SHALL keep a 3-bit saturating wait_cnt per requester: +1 when valid and not granted, cleared when granted or when valid=0, saturating at 7.
REQ-018 SHALL require the requester to hold valid and its payload stable until ready; a requester may drop valid before it is granted, which clears its wait_cnt and causes no output.
REQ-019 SHALL register the winner's outputs at the end of grant cycle N, with the outputs visible during cycle N+1 only; latency is 1 cycle, and back-to-back grants produce writes on consecutive cycles.
REQ-020 SHALL drive, in cycle N+1, reg_search_in = rd, reg_in = data, and reg_in_start = 1, except that reg_in_start = 0 when rd = 0; the stamp is still issued when rd = 0.
REQ-021 SHALL drive, in cycle N+1, stamp_in[slot] = 1 and stamp_flat[slot] = {stamp[2:1], 1'b1}, with the other stamp_flat fields 0.
REQ-022 SHALL return reg_in_start and stamp_in to 0 in any cycle that follows a cycle with no grant; reg_search_in, reg_in and stamp_flat hold their last values.
REQ-023 SHALL perform no same-rd hazard detection; writes to one rd are applied in grant order.
REQ-024 SHALL treat two requesters on the same slot as distinct requests, resolved by the index tie rule of REQ-016.

Reset
REQ-025 SHALL, while rst=1, force all wait_cnt to 0, req_ready to 0, and reg_search_in, reg_in, reg_in_start, stamp_flat and stamp_in to 0 on the next edge.
REQ-026 SHALL discard any output-stage write pending when rst asserts; the write in flight is not performed.
REQ-027 SHALL re-arbitrate a request held through reset in the first cycle with rst=0, with its wait_cnt starting at 0.

Verification
REQ-028 SHALL cover a single request: k=2, slot 5, stamp 3'b100, rd 7, data 0xDEADBEEF -> req_ready=4'b0100 in cycle N; in N+1, reg_in_start=1, reg_search_in=7, reg_in=0xDEADBEEF, stamp_in=8'h20, stamp_flat[17:15]=3'b101.
REQ-029 SHALL cover age priority: k0 at slot 1 and k3 at slot 6 both valid -> k3 is granted first and k0 one cycle later; writes appear on consecutive cycles.
REQ-030 SHALL cover starvation with AGE_LIMIT=4: k1 at slot 0 valid while k0 at slot 7 is re-requested every cycle -> k1 is granted in its 5th waiting cycle.
REQ-031 SHALL cover the rd=0 case: rd=0, slot 2 -> reg_in_start stays 0 and stamp_in=8'h04 for one cycle.
REQ-032 SHALL cover reset during flight: grant in cycle N, rst=1 in cycle N+1 -> no write strobe, all outputs 0; a held request is re-granted in the first cycle after rst drops.
REQ-033 SHALL cover the same-slot tie: k1 and k2 both at slot 4 -> k1 is granted first, then k2.

Source files
------------

// File: rtl/wb_arbiter.sv
// Four-port writeback arbiter: oldest-slot-first with an aging override for
// starved requesters; the winner's write and stamp are registered for one cycle.
module wb_arbiter #(
   parameter int AGE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   req_valid,
   input  logic [11:0]  req_slot_flat,
   input  logic [11:0]  req_stamp_flat,
   input  logic [19:0]  req_rd_flat,
   input  logic [127:0] req_data_flat,
   output logic [3:0]   req_ready,
   output logic [4:0]   reg_search_in,
   output logic [31:0]  reg_in,
   output logic         reg_in_start,
   output logic [23:0]  stamp_flat,
   output logic [7:0]   stamp_in
);

   localparam logic [2:0] AGE_THRESH = 3'(AGE_LIMIT);

   logic [2:0]  wait_cnt [4];
   logic [3:0]  starved;
   logic        any_starved;
   logic        found;
   logic [1:0]  win;
   logic [2:0]  best_slot;
   logic        grant;

   logic [2:0]  win_slot;
   logic [2:0]  win_stamp;
   logic [4:0]  win_rd;
   logic [31:0] win_data;
   logic [23:0] stamp_flat_next;

   logic [4:0]  rd_q;
   logic [31:0] data_q;
   logic        start_q;
   logic [23:0] stamp_flat_q;
   logic [7:0]  stamp_in_q;

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      starved     = '0;
      any_starved = 1'b0;
      found       = 1'b0;
      win         = '0;
      best_slot   = '0;
      for (int k = 0; k < 4; k++) begin
         starved[k] = req_valid[k] && (wait_cnt[k] >= AGE_THRESH);
      end
      any_starved = |starved;
      // Strict '>' keeps the lowest index on equal slots.
      for (int k = 0; k < 4; k++) begin
         if (req_valid[k] && (!any_starved || starved[k]) &&
             (!found || req_slot_flat[3*k +: 3] > best_slot)) begin
            found     = 1'b1;
            win       = 2'(k);
            best_slot = req_slot_flat[3*k +: 3];
         end
      end
      req_ready = (found && !rst) ? (4'b0001 << win) : 4'b0000;
   end

   assign grant = |req_ready;

   always_comb begin
      win_slot  = req_slot_flat[3*win +: 3];
      win_stamp = req_stamp_flat[3*win +: 3];
      win_rd    = req_rd_flat[5*win +: 5];
      win_data  = req_data_flat[32*win +: 32];
      stamp_flat_next = '0;
      stamp_flat_next[3*win_slot +: 3] = {win_stamp[2:1], 1'b1};
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (rst || !req_valid[k] || req_ready[k]) begin
            wait_cnt[k] <= '0;
         end else if (wait_cnt[k] != 3'd7) begin
            wait_cnt[k] <= wait_cnt[k] + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q         <= '0;
         data_q       <= '0;
         start_q      <= 1'b0;
         stamp_flat_q <= '0;
         stamp_in_q   <= '0;
      end else if (grant) begin
         rd_q         <= win_rd;
         data_q       <= win_data;
         start_q      <= (win_rd != 5'd0);
         stamp_flat_q <= stamp_flat_next;
         stamp_in_q   <= 8'b1 << win_slot;
      end else begin
         start_q    <= 1'b0;
         stamp_in_q <= '0;
      end
   end

   // Masking with rst squashes a write already sitting in the output stage
   // when reset arrives, so the register file never sees it.
   assign reg_search_in = rst ? '0 : rd_q;
   assign reg_in        = rst ? '0 : data_q;
   assign reg_in_start  = start_q && !rst;
   assign stamp_flat    = rst ? '0 : stamp_flat_q;
   assign stamp_in      = rst ? '0 : stamp_in_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: the driver checks grants and queues the
// expected write; a monitor pops and compares each registered write.
module tb_wb_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   req_valid = '0;
   logic [11:0]  req_slot_flat;
   logic [11:0]  req_stamp_flat;
   logic [19:0]  req_rd_flat;
   logic [127:0] req_data_flat;
   logic [3:0]   req_ready;
   logic [4:0]   reg_search_in;
   logic [31:0]  reg_in;
   logic         reg_in_start;
   logic [23:0]  stamp_flat;
   logic [7:0]   stamp_in;

   logic [2:0]  b_slot  [4] = '{default: '0};
   logic [2:0]  b_stamp [4] = '{default: '0};
   logic [4:0]  b_rd    [4] = '{default: '0};
   logic [31:0] b_data  [4] = '{default: '0};

   typedef struct {
      int          due;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        start;
      logic [23:0] sflat;
      logic [7:0]  sin;
   } wr_t;

   wr_t sb_q [$];
   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;

   wb_arbiter #(.AGE_LIMIT(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_slot_flat  (req_slot_flat),
      .req_stamp_flat (req_stamp_flat),
      .req_rd_flat    (req_rd_flat),
      .req_data_flat  (req_data_flat),
      .req_ready      (req_ready),
      .reg_search_in  (reg_search_in),
      .reg_in         (reg_in),
      .reg_in_start   (reg_in_start),
      .stamp_flat     (stamp_flat),
      .stamp_in       (stamp_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      req_slot_flat  = '0;
      req_stamp_flat = '0;
      req_rd_flat    = '0;
      req_data_flat  = '0;
      for (int k = 0; k < 4; k++) begin
         req_slot_flat[3*k +: 3]   = b_slot[k];
         req_stamp_flat[3*k +: 3]  = b_stamp[k];
         req_rd_flat[5*k +: 5]     = b_rd[k];
         req_data_flat[32*k +: 32] = b_data[k];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int k, input logic [2:0] slot, input logic [2:0] stamp,
                          input logic [4:0] rd, input logic [31:0] data);
      b_slot[k]    = slot;
      b_stamp[k]   = stamp;
      b_rd[k]      = rd;
      b_data[k]    = data;
      req_valid[k] = 1'b1;
   endtask

   task automatic drop(input int k);
      req_valid[k] = 1'b0;
   endtask

   // One cycle: check the grant, queue the expected write for the next cycle.
   task automatic step(input logic [3:0] exp_ready, input string name);
      wr_t w;
      logic [2:0] f;
      @(negedge clk);
      check({name, "_ready"}, 64'(req_ready), 64'(exp_ready));
      if (rst) begin
         check({name, "_rst_outs"},
               {reg_search_in, reg_in, reg_in_start, stamp_flat, stamp_in}, '0);
      end
      for (int k = 0; k < 4; k++) begin
         if (exp_ready[k]) begin
            f       = {b_stamp[k][2:1], 1'b1};
            w.due   = cyc + 1;
            w.rd    = b_rd[k];
            w.data  = b_data[k];
            w.start = (b_rd[k] != 5'd0);
            w.sflat = 24'(f) << (3 * b_slot[k]);
            w.sin   = 8'b1 << b_slot[k];
            sb_q.push_back(w);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: a nonzero stamp_in marks a presented write.
   initial begin
      wr_t w;
      wr_t last;
      last = '{0, '0, '0, 1'b0, '0, '0};
      forever begin
         @(negedge clk);
         if (rst) begin
            last = '{0, '0, '0, 1'b0, '0, '0};
         end else if (stamp_in != 8'h00) begin
            if (sb_q.size() == 0 || sb_q[0].due != cyc) begin
               check("unexpected_write", 64'(stamp_in), 64'h0);
            end else begin
               w = sb_q.pop_front();
               check("wr_rd",     64'(reg_search_in), 64'(w.rd));
               check("wr_data",   64'(reg_in),        64'(w.data));
               check("wr_start",  64'(reg_in_start),  64'(w.start));
               check("wr_sflat",  64'(stamp_flat),    64'(w.sflat));
               check("wr_sin",    64'(stamp_in),      64'(w.sin));
               last = w;
            end
         end else begin
            if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
               w = sb_q.pop_front();
               check("missing_write", 64'(stamp_in), 64'(w.sin));
            end
            check("idle_start", 64'(reg_in_start), 64'h0);
            check("hold_rd",    64'(reg_search_in), 64'(last.rd));
            check("hold_data",  64'(reg_in),        64'(last.data));
            check("hold_sflat", 64'(stamp_flat),    64'(last.sflat));
         end
      end
   end

   initial begin
      // Reset with a request held through it.
      set_req(1, 3'd2, 3'b000, 5'd3, 32'h0000_0011);
      #1;
      step(4'b0000, "reset0");
      step(4'b0000, "reset1");
      rst = 1'b0;
      step(4'b0010, "held_through_reset");
      drop(1);
      step(4'b0000, "idle0");

      // Single request.
      set_req(2, 3'd5, 3'b100, 5'd7, 32'hDEAD_BEEF);
      step(4'b0100, "single");
      drop(2);
      step(4'b0000, "single_idle");

      // Age priority, back-to-back writes.
      set_req(0, 3'd1, 3'b010, 5'd1, 32'h1111_0000);
      set_req(3, 3'd6, 3'b111, 5'd2, 32'h2222_0000);
      step(4'b1000, "age_k3");
      drop(3);
      step(4'b0001, "age_k0");
      drop(0);
      step(4'b0000, "age_idle");

      // Starvation: k1 at slot 0 against k0 at slot 7 re-requesting.
      set_req(1, 3'd0, 3'b001, 5'd4, 32'hA1A1_A1A1);
      for (int i = 0; i < 4; i++) begin
         set_req(0, 3'd7, 3'b010, 5'd3, 32'h0000_0100 + 32'(i));
         step(4'b0001, "starve_k0");
      end
      set_req(0, 3'd7, 3'b010, 5'd3, 32'h0000_0200);
      step(4'b0010, "starve_k1");
      drop(1);
      step(4'b0001, "starve_k0_after");

      // Dropping valid clears the age: 3 waits, drop, then 4 more waits.
      set_req(1, 3'd0, 3'b110, 5'd5, 32'hB2B2_B2B2);
      for (int i = 0; i < 3; i++) begin
         set_req(0, 3'd7, 3'b000, 5'd6, 32'h0000_0300 + 32'(i));
         step(4'b0001, "clr_k0");
      end
      drop(1);
      set_req(0, 3'd7, 3'b000, 5'd6, 32'h0000_0400);
      step(4'b0001, "clr_drop");
      set_req(1, 3'd0, 3'b110, 5'd5, 32'hB2B2_B2B2);
      for (int i = 0; i < 4; i++) begin
         set_req(0, 3'd7, 3'b000, 5'd6, 32'h0000_0500 + 32'(i));
         step(4'b0001, "clr_rewait");
      end
      step(4'b0010, "clr_k1");
      drop(1);
      drop(0);
      step(4'b0000, "clr_idle");

      // rd = 0: stamp issued, no register write strobe.
      set_req(3, 3'd2, 3'b011, 5'd0, 32'h5555_5555);
      step(4'b1000, "rd0");
      drop(3);
      step(4'b0000, "rd0_idle");

      // Same-slot tie.
      set_req(1, 3'd4, 3'b101, 5'd8,  32'h0000_0001);
      set_req(2, 3'd4, 3'b110, 5'd9,  32'h0000_0002);
      step(4'b0010, "tie_k1");
      drop(1);
      step(4'b0100, "tie_k2");
      drop(2);
      step(4'b0000, "tie_idle");

      // Reset while a write is in flight; request held and re-granted.
      set_req(1, 3'd3, 3'b110, 5'd9, 32'h1234_5678);
      step(4'b0010, "flight_grant");
      rst = 1'b1;
      sb_q.delete();
      step(4'b0000, "flight_rst");
      rst = 1'b0;
      step(4'b0010, "flight_regrant");
      drop(1);
      step(4'b0000, "flight_idle");
      step(4'b0000, "final_idle");

      check("sb_empty", 64'(sb_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
